alarm_entry_ctrl: RTL

//  Keypad-entry controller for the alarm clock. Collects BCD digits from the keypad into a
//  4-digit buffer and sequences the alarm register (load_alarm) and time counter
//  (load_new_time). Drives the display-select flags and discards stale entries on a timeout.

---
 rtl/alarm_entry_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/alarm_entry_ctrl.sv
// rtl/alarm_entry_ctrl.sv - keypad entry FSM sequencing alarm/time loads with an entry timeout.
// Optional ALARM_ENTRY_VALIDATE_EN: reject out-of-range HH:MM entries with bad_entry instead of loading.
module alarm_entry_ctrl #(
  parameter int TIMEOUT_SEC = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk256,
  input  logic        reset,
  input  logic        one_second,
  input  logic        key_valid,
  input  logic [3:0]  key,
  input  logic        alarm_button,
  input  logic        time_button,
  output logic [15:0] key_buffer,
  output logic        load_alarm,
  output logic        load_new_time,
  output logic        show_alarm,
  output logic        show_new_time,
  output logic        bad_entry
);

  typedef enum logic [2:0] {
    IDLE,
    SHOW_ALARM,
    KEY_ENTRY,
    SET_ALARM,
    SET_TIME
  } state_t;

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_SEC - 1);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             alarm_q;
  logic             time_q;
  logic             key_ok;
  logic             alarm_rise;
  logic             time_rise;
  logic             entry_ok;

  assign key_ok     = key_valid & (key <= 4'd9);
  assign alarm_rise = alarm_button & ~alarm_q;
  assign time_rise  = time_button & ~time_q;

`ifdef ALARM_ENTRY_VALIDATE_EN
  logic hours_bad;
  logic mins_bad;
  assign hours_bad = (key_buffer[15:12] > 4'd2) || (key_buffer[11:8] > 4'd9) ||
                     ((key_buffer[15:12] == 4'd2) && (key_buffer[11:8] > 4'd3));
  assign mins_bad  = (key_buffer[7:4] > 4'd5) || (key_buffer[3:0] > 4'd9);
  assign entry_ok  = ~hours_bad & ~mins_bad;
`else
  assign entry_ok  = 1'b1;
`endif

  always_ff @(posedge clk256) begin
    if (reset) begin
      state         <= IDLE;
      count         <= '0;
      alarm_q       <= 1'b0;
      time_q        <= 1'b0;
      key_buffer    <= '0;
      load_alarm    <= 1'b0;
      load_new_time <= 1'b0;
      show_alarm    <= 1'b0;
      show_new_time <= 1'b0;
      bad_entry     <= 1'b0;
    end else begin
      alarm_q       <= alarm_button;
      time_q        <= time_button;
      load_alarm    <= 1'b0;
      load_new_time <= 1'b0;
      bad_entry     <= 1'b0;
      case (state)
        IDLE: begin
          if (alarm_button) begin
            state      <= SHOW_ALARM;
            show_alarm <= 1'b1;
          end else if (key_ok) begin
            state         <= KEY_ENTRY;
            show_new_time <= 1'b1;
            key_buffer    <= {12'h000, key};
            count         <= '0;
          end
        end
        SHOW_ALARM: begin
          if (!alarm_button) begin
            state      <= IDLE;
            show_alarm <= 1'b0;
          end
        end
        KEY_ENTRY: begin
          // The load strobe reflects the buffer as it stands; a coincident key is dropped.
          if (alarm_rise) begin
            state         <= SET_ALARM;
            show_new_time <= 1'b0;
            load_alarm    <= entry_ok;
            bad_entry     <= ~entry_ok;
          end else if (time_rise) begin
            state         <= SET_TIME;
            show_new_time <= 1'b0;
            load_new_time <= entry_ok;
            bad_entry     <= ~entry_ok;
          end else if (key_ok) begin
            key_buffer <= {key_buffer[11:0], key};
            count      <= '0;
          end else if (one_second) begin
            if (count == LAST_COUNT) begin
              state         <= IDLE;
              show_new_time <= 1'b0;
              key_buffer    <= '0;
              count         <= '0;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
        end
        SET_ALARM, SET_TIME: begin
          state      <= IDLE;
          key_buffer <= '0;
          count      <= '0;
        end
        default: begin
          state         <= IDLE;
          key_buffer    <= '0;
          count         <= '0;
          show_alarm    <= 1'b0;
          show_new_time <= 1'b0;
        end
      endcase
    end
  end

endmodule
